lz_token_scheduler: RTL and testbench

Sequences LZ77 tokens onto the shared Huffman table port, sitting between the LZ77 engine and the Huffman encoder. It buffers tokens in a small FIFO and classifies each one as a literal or a match. Each literal becomes one literal-encode pulse; each match becomes a length-encode pulse followed by a distance-encode pulse. The block honours downstream `stall`, provides upstream backpressure, and supports a flush handshake plus a token counter.

---
 rtl/lz_token_scheduler.sv | 153 +++++++++++++++
 tb/tb_lz_token_scheduler.sv | 450 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lz_token_scheduler.sv
// LZ77 token scheduler: buffers tokens and serialises them onto the shared Huffman
// table port as literal pulses or length/distance pulse pairs.
module lz_token_scheduler #(
  parameter int FIFO_DEPTH = 4,
  parameter int FIFO_BITS  = 2,
  parameter int MIN_MATCH  = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        tok_valid,
  input  logic [10:0] tok_distance,
  input  logic [7:0]  tok_length,
  input  logic [7:0]  tok_literal,
  output logic        tok_ready,
  input  logic        stall,
  input  logic        flush,
  output logic        lit_en,
  output logic        len_en,
  output logic        dist_en,
  output logic [7:0]  lit_code,
  output logic [8:0]  len_code,
  output logic [15:0] dist_code,
  output logic        busy,
  output logic        flush_done,
  output logic [15:0] token_count
);

  localparam int                   ENTRY_W     = 27;
  localparam logic [FIFO_BITS:0]   DEPTH_C     = (FIFO_BITS+1)'(FIFO_DEPTH);
  localparam logic [FIFO_BITS:0]   CNT_ONE     = (FIFO_BITS+1)'(1);
  localparam logic [FIFO_BITS-1:0] PTR_ONE     = FIFO_BITS'(1);
  localparam logic [7:0]           MIN_MATCH_C = 8'(MIN_MATCH);

  typedef enum logic {IDLE = 1'b0, DIST = 1'b1} state_t;

  logic [ENTRY_W-1:0]   mem [FIFO_DEPTH];
  logic [FIFO_BITS-1:0] wr_ptr;
  logic [FIFO_BITS-1:0] rd_ptr;
  logic [FIFO_BITS:0]   count;
  logic                 flush_pending;
  state_t               state;
  state_t               state_nxt;
  logic                 push;
  logic                 pop;
  logic                 head_valid;
  logic                 head_is_match;
  logic                 drain_done;
  logic                 lit_vld_p0;
  logic                 len_vld_p0;
  logic                 dist_vld_p0;
  logic [10:0]          hd_distance;
  logic [7:0]           hd_length;
  logic [7:0]           hd_literal;

  function automatic logic is_match(input logic [7:0] len);
    return len >= MIN_MATCH_C;
  endfunction

  assign {hd_distance, hd_length, hd_literal} = mem[rd_ptr];
  assign head_valid    = (count != '0);
  assign head_is_match = is_match(hd_length);
  assign tok_ready     = (count < DEPTH_C) && !flush_pending;
  assign push          = tok_valid && tok_ready;
  assign pop           = lit_vld_p0 || dist_vld_p0;
  assign busy          = head_valid || (state != IDLE);

  // Token FIFO: a match stays at the head until its distance has been issued
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= {tok_distance, tok_length, tok_literal};
  end

  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (head_valid && !stall && head_is_match) state_nxt = DIST;
      DIST: if (!stall) state_nxt = IDLE;
    endcase
  end

  // Stage p0: issue decision for the head token
  always_comb begin
    lit_vld_p0  = 1'b0;
    len_vld_p0  = 1'b0;
    dist_vld_p0 = 1'b0;
    unique case (state)
      IDLE: begin
        if (head_valid && !stall) begin
          if (head_is_match) len_vld_p0 = 1'b1;
          else               lit_vld_p0 = 1'b1;
        end
      end
      DIST: if (!stall) dist_vld_p0 = 1'b1;
    endcase
  end

  // Stage p1: registered encode pulses; codes hold while their enable is low
  always_ff @(posedge clock) begin
    if (!reset) begin
      lit_en      <= 1'b0;
      len_en      <= 1'b0;
      dist_en     <= 1'b0;
      lit_code    <= '0;
      len_code    <= '0;
      dist_code   <= '0;
      token_count <= '0;
    end else begin
      lit_en  <= lit_vld_p0;
      len_en  <= len_vld_p0;
      dist_en <= dist_vld_p0;
      if (lit_vld_p0)  lit_code  <= hd_literal;
      if (len_vld_p0)  len_code  <= {1'b0, hd_length};
      if (dist_vld_p0) dist_code <= {5'b0, hd_distance};
      if (lit_en || dist_en) token_count <= token_count + 16'd1;
    end
  end

  // A fresh flush on an idle, empty block completes on the very next cycle
  assign drain_done = (flush_pending || flush) && (count == '0) && (state == IDLE)
                      && !(lit_en || len_en || dist_en);

  always_ff @(posedge clock) begin
    if (!reset) begin
      flush_pending <= 1'b0;
      flush_done    <= 1'b0;
    end else begin
      flush_done <= drain_done;
      if (drain_done) flush_pending <= 1'b0;
      else if (flush) flush_pending <= 1'b1;
    end
  end

endmodule

// File: tb/tb_lz_token_scheduler.sv
// Testbench for lz_token_scheduler: directed scenarios plus a randomized run checked
// against a token-level model of the expected encode pulse sequence.
module tb_lz_token_scheduler;

  logic        clock = 1'b0;
  logic        reset;
  logic        tok_valid;
  logic [10:0] tok_distance;
  logic [7:0]  tok_length;
  logic [7:0]  tok_literal;
  logic        tok_ready;
  logic        stall;
  logic        flush;
  logic        lit_en, len_en, dist_en;
  logic [7:0]  lit_code;
  logic [8:0]  len_code;
  logic [15:0] dist_code;
  logic        busy;
  logic        flush_done;
  logic [15:0] token_count;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  bit mon_on = 1'b0;

  // Observed pulses (kind 0 = literal, 1 = length, 2 = distance) and expected ones
  int ev_kind[$], ev_code[$], ev_cyc[$], fd_cyc[$];
  int exp_kind[$], exp_code[$];
  int exp_ntok;

  lz_token_scheduler #(.FIFO_DEPTH(4), .FIFO_BITS(2), .MIN_MATCH(3)) dut (
    .clock(clock), .reset(reset), .tok_valid(tok_valid), .tok_distance(tok_distance),
    .tok_length(tok_length), .tok_literal(tok_literal), .tok_ready(tok_ready),
    .stall(stall), .flush(flush), .lit_en(lit_en), .len_en(len_en), .dist_en(dist_en),
    .lit_code(lit_code), .len_code(len_code), .dist_code(dist_code), .busy(busy),
    .flush_done(flush_done), .token_count(token_count)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (mon_on) begin
      if (lit_en)  begin ev_kind.push_back(0); ev_code.push_back(int'(lit_code));  ev_cyc.push_back(cyc); end
      if (len_en)  begin ev_kind.push_back(1); ev_code.push_back(int'(len_code));  ev_cyc.push_back(cyc); end
      if (dist_en) begin ev_kind.push_back(2); ev_code.push_back(int'(dist_code)); ev_cyc.push_back(cyc); end
      if (flush_done) fd_cyc.push_back(cyc);
      if (lit_en || len_en || dist_en) begin
        n_cmp++;
        if ($countones({lit_en, len_en, dist_en}) != 1) begin
          n_err++;
          $display("FAIL onehot_enables: got %b required exactly one set", {lit_en, len_en, dist_en});
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    tok_valid = 1'b0; tok_distance = '0; tok_length = '0; tok_literal = '0;
    stall = 1'b0; flush = 1'b0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    reset = 1'b0;
    step();
    reset = 1'b1;
  endtask

  task automatic clear_model();
    ev_kind.delete(); ev_code.delete(); ev_cyc.delete(); fd_cyc.delete();
    exp_kind.delete(); exp_code.delete();
    exp_ntok = 0;
  endtask

  // Each accepted token expands into its pulse sequence
  function automatic void model_push(input int d, input int l, input int c);
    if (l >= 3) begin
      exp_kind.push_back(1); exp_code.push_back(l);
      exp_kind.push_back(2); exp_code.push_back(d);
    end else begin
      exp_kind.push_back(0); exp_code.push_back(c);
    end
    exp_ntok++;
  endfunction

  task automatic push_token(input int d, input int l, input int c);
    int waited = 0;
    tok_valid = 1'b1; tok_distance = 11'(d); tok_length = 8'(l); tok_literal = 8'(c);
    while (!tok_ready && waited < 50) begin
      step();
      waited++;
    end
    n_cmp++;
    if (!tok_ready) begin
      n_err++;
      $display("FAIL push_timeout: tok_ready=%b required 1 within 50 cycles", tok_ready);
    end else begin
      model_push(d, l, c);
    end
    step();
    tok_valid = 1'b0;
  endtask

  task automatic wait_quiet(input int budget, output bit ok);
    int quiet = 0;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (!busy && !lit_en && !len_en && !dist_en) quiet++;
      else quiet = 0;
      if (quiet >= 2) begin ok = 1'b1; break; end
    end
    repeat (3) step();
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b0;
    step(); step();
    reset = 1'b1;
    step();
    n_cmp++;
    if ({lit_en, len_en, dist_en, flush_done, busy} !== 5'b0) begin
      n_err++; $display("FAIL reset_flags: got %b required 00000", {lit_en, len_en, dist_en, flush_done, busy});
    end
    n_cmp++;
    if ({lit_code, len_code, dist_code} !== 33'b0) begin
      n_err++; $display("FAIL reset_codes: got %0h/%0h/%0h required 0", lit_code, len_code, dist_code);
    end
    n_cmp++;
    if (token_count !== 16'd0) begin
      n_err++; $display("FAIL reset_count: got %0d required 0", token_count);
    end
    n_cmp++;
    if (tok_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_ready: got %b required 1", tok_ready);
    end
  endtask

  task automatic test_lit_then_match();
    apply_reset();
    tok_valid = 1'b1; tok_literal = 8'h41; tok_length = 8'd0; tok_distance = 11'd0;
    step();
    tok_literal = 8'h00; tok_length = 8'd5; tok_distance = 11'd12;
    n_cmp++;
    if (lit_en !== 1'b0) begin n_err++; $display("FAIL ltm_c1_lit: got %b required 0", lit_en); end
    step();
    tok_valid = 1'b0;
    n_cmp++;
    if (lit_en !== 1'b1 || lit_code !== 8'h41 || len_en !== 1'b0) begin
      n_err++; $display("FAIL ltm_c2_lit: got en=%b code=%0h len_en=%b required 1/41/0", lit_en, lit_code, len_en);
    end
    step();
    n_cmp++;
    if (len_en !== 1'b1 || len_code !== 9'd5 || lit_en !== 1'b0 || dist_en !== 1'b0) begin
      n_err++; $display("FAIL ltm_c3_len: got en=%b code=%0d lit=%b dist=%b required 1/5/0/0", len_en, len_code, lit_en, dist_en);
    end
    step();
    n_cmp++;
    if (dist_en !== 1'b1 || dist_code !== 16'd12 || len_en !== 1'b0) begin
      n_err++; $display("FAIL ltm_c4_dist: got en=%b code=%0d len_en=%b required 1/12/0", dist_en, dist_code, len_en);
    end
    step();
    n_cmp++;
    if (token_count !== 16'd2 || dist_en !== 1'b0) begin
      n_err++; $display("FAIL ltm_count: got count=%0d dist_en=%b required 2/0", token_count, dist_en);
    end
  endtask

  task automatic test_min_match();
    bit ok;
    apply_reset();
    clear_model();
    mon_on = 1'b1;
    push_token(7, 2, 8'h55);
    push_token(9, 3, 8'h66);
    wait_quiet(30, ok);
    mon_on = 1'b0;
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL minm_quiet: got busy=%b required idle", busy); end
    n_cmp++;
    if (ev_kind.size() != exp_kind.size()) begin
      n_err++; $display("FAIL minm_events: got %0d pulses required %0d", ev_kind.size(), exp_kind.size());
    end
    foreach (exp_kind[i]) begin
      n_cmp++;
      if (ev_kind[i] != exp_kind[i] || ev_code[i] != exp_code[i]) begin
        n_err++; $display("FAIL minm_pulse%0d: got kind=%0d code=%0h required kind=%0d code=%0h", i, ev_kind[i], ev_code[i], exp_kind[i], exp_code[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    apply_reset();
    clear_model();
    mon_on = 1'b1;
    push_token(1, 0, 8'hA0);
    push_token(2, 1, 8'hA1);
    push_token(3, 2, 8'hA2);
    push_token(300, 10, 8'hA3);
    push_token(2047, 255, 8'hA4);
    push_token(5, 0, 8'hA5);
    wait_quiet(40, ok);
    mon_on = 1'b0;
    n_cmp++;
    if (ev_kind.size() != exp_kind.size() || !ok) begin
      n_err++; $display("FAIL b2b_events: got %0d pulses required %0d", ev_kind.size(), exp_kind.size());
    end
    foreach (exp_kind[i]) begin
      n_cmp++;
      if (ev_kind[i] != exp_kind[i] || ev_code[i] != exp_code[i] || ev_cyc[i] != ev_cyc[0] + i) begin
        n_err++; $display("FAIL b2b_pulse%0d: got kind=%0d code=%0h cyc+%0d required kind=%0d code=%0h cyc+%0d",
                          i, ev_kind[i], ev_code[i], ev_cyc[i] - ev_cyc[0], exp_kind[i], exp_code[i], i);
      end
    end
    n_cmp++;
    if (token_count !== 16'(exp_ntok)) begin
      n_err++; $display("FAIL b2b_count: got %0d required %0d", token_count, exp_ntok);
    end
  endtask

  task automatic test_full_fifo();
    bit ok;
    bit rdy[5];
    apply_reset();
    clear_model();
    mon_on = 1'b1;
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tok_valid = 1'b1; tok_literal = 8'(8'h10 + i); tok_length = 8'(i % 3); tok_distance = 11'(i);
      rdy[i] = tok_ready;
      if (tok_ready) model_push(i, i % 3, 8'h10 + i);
      step();
    end
    tok_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (rdy[i] != (i < 4)) begin
        n_err++; $display("FAIL full_ready%0d: got %b required %b", i, rdy[i], (i < 4));
      end
    end
    n_cmp++;
    if (ev_kind.size() != 0 || busy !== 1'b1) begin
      n_err++; $display("FAIL full_stalled: got %0d pulses busy=%b required 0/1", ev_kind.size(), busy);
    end
    stall = 1'b0;
    n_cmp++;
    if (tok_ready !== 1'b0) begin n_err++; $display("FAIL full_ready_release: got %b required 0", tok_ready); end
    step();
    n_cmp++;
    if (tok_ready !== 1'b1 || lit_en !== 1'b1 || lit_code !== 8'h10) begin
      n_err++; $display("FAIL full_first_pop: got ready=%b lit=%b code=%0h required 1/1/10", tok_ready, lit_en, lit_code);
    end
    wait_quiet(30, ok);
    mon_on = 1'b0;
    n_cmp++;
    if (ev_kind.size() != exp_kind.size() || !ok) begin
      n_err++; $display("FAIL full_events: got %0d pulses required %0d", ev_kind.size(), exp_kind.size());
    end
    foreach (exp_kind[i]) begin
      n_cmp++;
      if (ev_kind[i] != exp_kind[i] || ev_code[i] != exp_code[i]) begin
        n_err++; $display("FAIL full_pulse%0d: got kind=%0d code=%0h required kind=%0d code=%0h", i, ev_kind[i], ev_code[i], exp_kind[i], exp_code[i]);
      end
    end
    n_cmp++;
    if (token_count !== 16'd4) begin n_err++; $display("FAIL full_count: got %0d required 4", token_count); end
  endtask

  task automatic test_stall_dist();
    apply_reset();
    tok_valid = 1'b1; tok_length = 8'd7; tok_distance = 11'h123; tok_literal = 8'hAA;
    step();
    tok_valid = 1'b0;
    step();
    n_cmp++;
    if (len_en !== 1'b1 || len_code !== 9'd7) begin
      n_err++; $display("FAIL sd_len: got en=%b code=%0d required 1/7", len_en, len_code);
    end
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      if (i == 2) stall = 1'b0;
      n_cmp++;
      if (len_en !== 1'b0 || dist_en !== 1'b0 || busy !== 1'b1) begin
        n_err++; $display("FAIL sd_hold%0d: got len=%b dist=%b busy=%b required 0/0/1", i, len_en, dist_en, busy);
      end
    end
    step();
    n_cmp++;
    if (dist_en !== 1'b1 || dist_code !== 16'h0123 || len_en !== 1'b0) begin
      n_err++; $display("FAIL sd_dist: got en=%b code=%0h len=%b required 1/123/0", dist_en, dist_code, len_en);
    end
    step();
    step();
    n_cmp++;
    if (dist_en !== 1'b0 || len_en !== 1'b0 || busy !== 1'b0 || token_count !== 16'd1) begin
      n_err++; $display("FAIL sd_after: got dist=%b len=%b busy=%b count=%0d required 0/0/0/1", dist_en, len_en, busy, token_count);
    end
  endtask

  task automatic test_flush();
    bit ok;
    apply_reset();
    clear_model();
    mon_on = 1'b1;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tok_valid = 1'b1; tok_literal = 8'(8'hC0 + i); tok_length = 8'd0; tok_distance = 11'd0;
      model_push(0, 0, 8'hC0 + i);
      step();
    end
    tok_valid = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    stall = 1'b0;
    n_cmp++;
    if (tok_ready !== 1'b0) begin n_err++; $display("FAIL fl_ready_low: got %b required 0", tok_ready); end
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    wait_quiet(30, ok);
    mon_on = 1'b0;
    n_cmp++;
    if (ev_kind.size() != 3 || !ok) begin
      n_err++; $display("FAIL fl_lits: got %0d pulses required 3", ev_kind.size());
    end
    foreach (exp_kind[i]) begin
      n_cmp++;
      if (ev_kind[i] != exp_kind[i] || ev_code[i] != exp_code[i]) begin
        n_err++; $display("FAIL fl_pulse%0d: got kind=%0d code=%0h required kind=%0d code=%0h", i, ev_kind[i], ev_code[i], exp_kind[i], exp_code[i]);
      end
    end
    n_cmp++;
    if (fd_cyc.size() != 1) begin
      n_err++; $display("FAIL fl_done_count: got %0d required 1", fd_cyc.size());
    end else begin
      n_cmp++;
      if (ev_kind.size() > 0 && fd_cyc[0] <= ev_cyc[ev_cyc.size()-1]) begin
        n_err++; $display("FAIL fl_done_order: got done at %0d required after %0d", fd_cyc[0], ev_cyc[ev_cyc.size()-1]);
      end
    end
    n_cmp++;
    if (tok_ready !== 1'b1) begin n_err++; $display("FAIL fl_ready_back: got %b required 1", tok_ready); end
    flush = 1'b1;
    step();
    flush = 1'b0;
    n_cmp++;
    if (flush_done !== 1'b1) begin n_err++; $display("FAIL fl_empty_done: got %b required 1", flush_done); end
    step();
    n_cmp++;
    if (flush_done !== 1'b0 || tok_ready !== 1'b1) begin
      n_err++; $display("FAIL fl_empty_after: got done=%b ready=%b required 0/1", flush_done, tok_ready);
    end
  endtask

  task automatic test_reset_mid_match();
    int dist_seen = 0;
    apply_reset();
    clear_model();
    mon_on = 1'b1;
    tok_valid = 1'b1; tok_length = 8'd4; tok_distance = 11'h055; tok_literal = 8'h00;
    step();
    tok_valid = 1'b0;
    step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    repeat (5) step();
    mon_on = 1'b0;
    foreach (ev_kind[i]) if (ev_kind[i] == 2) dist_seen++;
    n_cmp++;
    if (dist_seen != 0) begin n_err++; $display("FAIL rmm_dist: got %0d dist pulses required 0", dist_seen); end
    n_cmp++;
    if (busy !== 1'b0 || token_count !== 16'd0 || tok_ready !== 1'b1) begin
      n_err++; $display("FAIL rmm_state: got busy=%b count=%0d ready=%b required 0/0/1", busy, token_count, tok_ready);
    end
  endtask

  task automatic test_random();
    bit ok;
    int d, l, c;
    apply_reset();
    clear_model();
    mon_on = 1'b1;
    for (int i = 0; i < 400; i++) begin
      d = $urandom_range(0, 2047);
      l = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 5);
      c = $urandom_range(0, 255);
      tok_valid = ($urandom_range(0, 99) < 60);
      tok_distance = 11'(d); tok_length = 8'(l); tok_literal = 8'(c);
      stall = ($urandom_range(0, 99) < 25);
      flush = ($urandom_range(0, 99) < 2);
      if (tok_valid && tok_ready) model_push(d, l, c);
      step();
    end
    idle_inputs();
    wait_quiet(200, ok);
    mon_on = 1'b0;
    n_cmp++;
    if (ev_kind.size() != exp_kind.size() || !ok) begin
      n_err++; $display("FAIL rnd_events: got %0d pulses required %0d", ev_kind.size(), exp_kind.size());
    end
    foreach (exp_kind[i]) begin
      n_cmp++;
      if (ev_kind[i] != exp_kind[i] || ev_code[i] != exp_code[i]) begin
        n_err++; $display("FAIL rnd_pulse%0d: got kind=%0d code=%0h required kind=%0d code=%0h", i, ev_kind[i], ev_code[i], exp_kind[i], exp_code[i]);
      end
    end
    n_cmp++;
    if (token_count !== 16'(exp_ntok)) begin
      n_err++; $display("FAIL rnd_count: got %0d required %0d", token_count, exp_ntok);
    end
  endtask

  initial begin
    idle_inputs();
    reset = 1'b0;
    clear_model();
    test_reset();
    test_lit_then_match();
    test_min_match();
    test_back_to_back();
    test_full_fifo();
    test_stall_dist();
    test_flush();
    test_reset_mid_match();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
